// File: rtl/flash_pkg.sv
// Shared definitions for the flash programming controller: state encoding
// and default geometry/timeout values.
package flash_pkg;

  localparam int unsigned PAGE_BYTES_DEF  = 256;
  localparam int unsigned ACK_TIMEOUT_DEF = 1023;
  localparam int unsigned BYTE_CNT_W      = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CHECK,
    ST_FETCH,
    ST_PRESENT,
    ST_WAIT_ACK,
    ST_PAGE_GAP,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/flash_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module flash_wait_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the count parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/flash_prog_ctrl.sv
// Sequences 16-bit FIFO words out as bytes to a page-based SPI flash writer,
// with ack timeout, page gaps and base-path read pass-through while idle.
module flash_prog_ctrl
  import flash_pkg::*;
#(
  parameter int unsigned PAGE_BYTES  = PAGE_BYTES_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len_words,
  input  logic        abort,
  input  logic [9:0]  fifo_cnt,
  input  logic        base_req,
  input  logic        spi_busy,
  input  logic        spi_ack,
  output logic        f_prog,
  output logic        rd_flash,
  output logic        rd_base,
  output logic        spi_wr,
  output logic        page_done,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned PAGE_W = $clog2(PAGE_BYTES);
  localparam int unsigned TMR_W  = $clog2(ACK_TIMEOUT + 1);
  // Timer is loaded in FETCH and runs from the first spi_wr cycle, so the
  // job gives up after exactly ACK_TIMEOUT cycles of spi_wr without an ack.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  state_t state, state_nxt;

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [BYTE_CNT_W-1:0] byte_total;
  logic [BYTE_CNT_W-1:0] cnt_inc;
  logic                  arm_cnt;
  logic                  pop_hold;
  logic                  err_q;
  logic                  done_q;
  logic                  page_done_q;

  logic start_ok;
  logic ack_take;
  logic timeout;
  logic done_set;
  logic tmr_load;
  logic tmr_en;
  logic tmr_expired;
  logic last_byte;
  logic page_end;

  assign cnt_inc   = byte_cnt + BYTE_CNT_W'(1);
  assign last_byte = (cnt_inc == byte_total);
  assign page_end  = (cnt_inc[PAGE_W-1:0] == '0);

  flash_wait_timer #(
    .WIDTH(TMR_W)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .load_val(TMR_LOAD),
    .expired (tmr_expired)
  );

  // Next-state logic; abort overrides everything outside IDLE, including
  // an ack arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    ack_take  = 1'b0;
    timeout   = 1'b0;
    done_set  = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          if (len_words != '0) begin
            state_nxt = ST_ARM;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ST_ARM: begin
        if (arm_cnt) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Low bytes come from the word already loaded; high bytes need a
        // FIFO word, and the count is ignored for a cycle after a pop.
        if (!pop_hold && (byte_cnt[0] || (fifo_cnt != '0))) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        tmr_load  = 1'b1;
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        tmr_en    = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        if (spi_ack) begin
          ack_take = 1'b1;
          if (last_byte) begin
            state_nxt = ST_FINISH;
          end else if (page_end) begin
            state_nxt = ST_PAGE_GAP;
          end else begin
            state_nxt = ST_CHECK;
          end
        end else if (tmr_expired) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_PAGE_GAP: begin
        if (!spi_busy) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_FINISH: begin
        if (!spi_busy) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      ack_take  = 1'b0;
      timeout   = 1'b0;
      done_set  = 1'b0;
    end
  end

  // State, counters and the registered pulse/sticky outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      byte_total  <= '0;
      arm_cnt     <= 1'b0;
      pop_hold    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      page_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      done_q      <= done_set;
      page_done_q <= ack_take && (last_byte || page_end);
      arm_cnt     <= (state == ST_ARM) ? ~arm_cnt : 1'b0;

      if (state == ST_CHECK) begin
        pop_hold <= 1'b0;
      end

      if (start_ok) begin
        byte_total <= {len_words, 1'b0};
        byte_cnt   <= '0;
        err_q      <= 1'b0;
        pop_hold   <= 1'b0;
      end

      if (ack_take) begin
        byte_cnt <= cnt_inc;
        if (byte_cnt[0]) begin
          pop_hold <= 1'b1;
        end
      end

      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign f_prog    = (state != ST_IDLE);
  assign rd_flash  = (state == ST_FETCH);
  assign spi_wr    = (state == ST_PRESENT) || (state == ST_WAIT_ACK);
  assign rd_base   = !rst && (state == ST_IDLE) && base_req && (fifo_cnt != '0);
  assign page_done = page_done_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed self-checking bench for flash_prog_ctrl with a small flash
// writer model (delayed ack, optional busy after each page).
module tb_flash_prog_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len_words;
  logic        abort;
  logic [9:0]  fifo_cnt;
  logic        base_req;
  logic        spi_busy;
  logic        spi_ack;
  logic        f_prog;
  logic        rd_flash;
  logic        rd_base;
  logic        spi_wr;
  logic        page_done;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;
  int cyc;
  int ack_cnt;
  int rdf_cnt;
  int rdf_busy_cnt;
  int pd_cnt;
  int done_cnt;
  int rdbase_busy_cnt;
  int fprog_cnt;
  int first_rdf_cyc;
  int first_wr_cyc;
  int err_cyc;
  int c0;
  int wr_age;
  int ack_delay;
  int busy_hold;
  bit ack_en;
  bit busy_model_en;
  int pd_ack [0:3];

  flash_prog_ctrl #(
    .PAGE_BYTES (16),
    .ACK_TIMEOUT(1023)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len_words(len_words),
    .abort    (abort),
    .fifo_cnt (fifo_cnt),
    .base_req (base_req),
    .spi_busy (spi_busy),
    .spi_ack  (spi_ack),
    .f_prog   (f_prog),
    .rd_flash (rd_flash),
    .rd_base  (rd_base),
    .spi_wr   (spi_wr),
    .page_done(page_done),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    ack_cnt         = 0;
    rdf_cnt         = 0;
    rdf_busy_cnt    = 0;
    pd_cnt          = 0;
    done_cnt        = 0;
    rdbase_busy_cnt = 0;
    fprog_cnt       = 0;
    first_rdf_cyc   = -1;
    first_wr_cyc    = -1;
    err_cyc         = -1;
    for (int i = 0; i < 4; i++) pd_ack[i] = -1;
  endtask

  // One clock: sample outputs 2ns after the edge, then update the writer model.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (rd_flash) begin
      rdf_cnt++;
      if (first_rdf_cyc < 0) first_rdf_cyc = cyc;
      if (spi_busy) rdf_busy_cnt++;
    end
    if (page_done) begin
      if (pd_cnt < 4) pd_ack[pd_cnt] = ack_cnt;
      pd_cnt++;
      if (busy_model_en) busy_hold = 20;
    end
    if (done) done_cnt++;
    if (f_prog) fprog_cnt++;
    if (busy && rd_base) rdbase_busy_cnt++;
    if (spi_wr && (first_wr_cyc < 0)) first_wr_cyc = cyc;
    if (spi_ack) begin
      spi_ack = 1'b0;
      wr_age  = 0;
    end else if (spi_wr && ack_en) begin
      wr_age++;
      if (wr_age == ack_delay) begin
        spi_ack = 1'b1;
        ack_cnt++;
      end
    end else if (!spi_wr) begin
      wr_age = 0;
    end
    if (busy_hold > 0) begin
      spi_busy = 1'b1;
      busy_hold--;
    end else begin
      spi_busy = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] len, input logic [9:0] fcnt);
    start     = 1'b1;
    len_words = len;
    fifo_cnt  = fcnt;
    tick();
    start = 1'b0;
  endtask

  task automatic runUntilDone(input int max_cycles);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done_cnt != d0) break;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    wr_age        = 0;
    ack_delay     = 2;
    ack_en        = 1'b1;
    busy_hold     = 0;
    busy_model_en = 1'b0;
    rst           = 1'b1;
    start         = 1'b0;
    len_words     = '0;
    abort         = 1'b0;
    fifo_cnt      = 10'd4;
    base_req      = 1'b1;
    spi_busy      = 1'b0;
    spi_ack       = 1'b0;
    clearCounts();

    // Reset state, with a base request pending that must stay masked.
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_f_prog", f_prog, 0);
    checkOutput("rst_spi_wr", spi_wr, 0);
    checkOutput("rst_rd_flash", rd_flash, 0);
    checkOutput("rst_rd_base", rd_base, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_page_done", page_done, 0);
    rst      = 1'b0;
    base_req = 1'b0;
    tick();

    // 3-word job, ack two cycles after spi_wr, base_req high and a stray start mid-job.
    $display("[TB] job of 3 words");
    clearCounts();
    base_req = 1'b1;
    applyStimulus(16'd3, 10'd3);
    c0 = cyc;
    checkOutput("t1_busy_after_start", busy, 1);
    checkOutput("t1_f_prog_after_start", f_prog, 1);
    checkOutput("t1_rd_base_in_job", rd_base, 0);
    repeat (8) tick();
    start     = 1'b1;
    len_words = 16'd1;
    tick();
    start = 1'b0;
    runUntilDone(300);
    checkOutput("t1_done_cnt", done_cnt, 1);
    checkOutput("t1_busy_at_done", busy, 0);
    checkOutput("t1_f_prog_at_done", f_prog, 0);
    checkOutput("t1_rd_flash_cnt", rdf_cnt, 6);
    checkOutput("t1_ack_cnt", ack_cnt, 6);
    checkOutput("t1_page_done_cnt", pd_cnt, 1);
    checkOutput("t1_page_done_byte", pd_ack[0], 6);
    checkOutput("t1_rd_base_busy_cnt", rdbase_busy_cnt, 0);
    checkOutput("t1_first_rd_flash_lat", first_rdf_cyc - c0, 3);
    checkOutput("t1_err", err, 0);
    base_req = 1'b0;
    tick();

    // 10 words over 16-byte pages, writer busy for 20 cycles after each page.
    $display("[TB] job of 10 words with page gaps");
    clearCounts();
    busy_model_en = 1'b1;
    applyStimulus(16'd10, 10'd10);
    runUntilDone(1500);
    checkOutput("t2_done_cnt", done_cnt, 1);
    checkOutput("t2_page_done_cnt", pd_cnt, 2);
    checkOutput("t2_page_done_byte0", pd_ack[0], 16);
    checkOutput("t2_page_done_byte1", pd_ack[1], 20);
    checkOutput("t2_rd_flash_cnt", rdf_cnt, 20);
    checkOutput("t2_rd_flash_while_busy", rdf_busy_cnt, 0);
    busy_model_en = 1'b0;
    repeat (22) tick();

    // Empty FIFO at a high byte stalls; odd byte proceeds with an empty FIFO.
    $display("[TB] FIFO starvation");
    clearCounts();
    applyStimulus(16'd1, 10'd0);
    repeat (50) tick();
    checkOutput("t3_no_rd_flash_starved", rdf_cnt, 0);
    checkOutput("t3_busy_starved", busy, 1);
    fifo_cnt = 10'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rdf_cnt != 0) break;
    end
    checkOutput("t3_rd_flash_after_fill", rdf_cnt, 1);
    fifo_cnt = 10'd0;
    runUntilDone(100);
    checkOutput("t3_rd_flash_total", rdf_cnt, 2);
    checkOutput("t3_done_cnt", done_cnt, 1);
    tick();

    // Writer never acks: timeout after 1023 spi_wr cycles.
    $display("[TB] ack timeout");
    clearCounts();
    ack_en = 1'b0;
    applyStimulus(16'd1, 10'd1);
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (err === 1'b1) begin
        err_cyc = cyc;
        break;
      end
    end
    checkOutput("t4_timeout_latency", err_cyc - first_wr_cyc, 1023);
    checkOutput("t4_f_prog_after_timeout", f_prog, 0);
    checkOutput("t4_busy_after_timeout", busy, 0);
    checkOutput("t4_spi_wr_after_timeout", spi_wr, 0);
    repeat (3) tick();
    checkOutput("t4_err_sticky", err, 1);
    checkOutput("t4_no_done", done_cnt, 0);
    ack_en = 1'b1;

    // Abort coinciding with ack, then a zero-length start alongside abort.
    $display("[TB] abort with ack");
    clearCounts();
    applyStimulus(16'd2, 10'd2);
    checkOutput("t5_err_cleared_by_start", err, 0);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (spi_ack) break;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_busy_after_abort", busy, 0);
    checkOutput("t5_f_prog_after_abort", f_prog, 0);
    checkOutput("t5_spi_wr_after_abort", spi_wr, 0);
    checkOutput("t5_page_done_after_abort", page_done, 0);
    checkOutput("t5_no_done_on_abort", done_cnt, 0);
    tick();
    clearCounts();
    start     = 1'b1;
    abort     = 1'b1;
    len_words = 16'd0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("t5_zero_len_done_next", done, 1);
    repeat (4) tick();
    checkOutput("t5_zero_len_done_cnt", done_cnt, 1);
    checkOutput("t5_zero_len_f_prog", fprog_cnt, 0);
    checkOutput("t5_zero_len_busy", busy, 0);

    // Reset in the middle of byte 5, then a base read request.
    $display("[TB] reset mid-job");
    clearCounts();
    applyStimulus(16'd3, 10'd3);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack_cnt == 4) break;
    end
    repeat (2) tick();
    checkOutput("t6_busy_before_rst", busy, 1);
    rst      = 1'b1;
    base_req = 1'b1;
    fifo_cnt = 10'd4;
    tick();
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_f_prog", f_prog, 0);
    checkOutput("t6_rst_rd_flash", rd_flash, 0);
    checkOutput("t6_rst_rd_base", rd_base, 0);
    checkOutput("t6_rst_spi_wr", spi_wr, 0);
    checkOutput("t6_rst_page_done", page_done, 0);
    checkOutput("t6_rst_done", done, 0);
    checkOutput("t6_rst_err", err, 0);
    rst = 1'b0;
    #1;
    checkOutput("t6_rd_base_after_rst", rd_base, 1);
    tick();
    checkOutput("t6_rd_base_idle", rd_base, 1);
    checkOutput("t6_busy_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
